// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op encodings and decode helpers shared by the arithmetic lanes
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SLTU = 2'b10,
    OP_SLT  = 2'b11
  } op_t;

  // Op 10 only subtracts when the unsigned compare is built; otherwise it aliases ADD.
  function automatic logic op_is_sub(input op_t o);
`ifdef ADDSUB_SLTU_EN
    return (o != OP_ADD);
`else
    return o[0];
`endif
  endfunction

endpackage

// File: rtl/add_segment.sv
// rtl/add_segment.sv - W-bit ripple adder slice with carry-in, carry-out and carry-into-MSB
module add_segment #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum  = full[W-1:0];
  assign cout = full[W];
  // Carry into the top bit recovered from the top-bit sum: s = a ^ b ^ c.
  assign cmsb = a[W-1] ^ b[W-1] ^ full[W-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - segmented-carry pipelined ADD/SUB/SLT lane; ADDSUB_SLTU_EN builds SLTU on op 10
module pipelined_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             cout
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_add_sub: WIDTH must be >= 2 and divisible by STAGES");
  end

  logic             adv;
  op_t              op_in;
  logic             v_r    [STAGES];
  op_t              op_r   [STAGES];
  logic [WIDTH-1:0] a_r    [STAGES];
  logic [WIDTH-1:0] b_r    [STAGES];
  logic [WIDTH-1:0] s_r    [STAGES];
  logic             c_r    [STAGES];
  logic [SEG-1:0]   seg_sum[STAGES];
  logic             seg_co [STAGES];
  logic             seg_cm [STAGES];
  logic [WIDTH-1:0] s_nxt  [STAGES];

  assign op_in    = op_t'(op);
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage k owns carry segment k; its finished slice is merged into the skewed sum.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_segment #(.W(SEG)) u_seg (
      .a    (a_r[k][k*SEG +: SEG]),
      .b    (b_r[k][k*SEG +: SEG]),
      .cin  (c_r[k]),
      .sum  (seg_sum[k]),
      .cout (seg_co[k]),
      .cmsb (seg_cm[k])
    );

    always_comb begin
      s_nxt[k]                = s_r[k];
      s_nxt[k][k*SEG +: SEG]  = seg_sum[k];
    end
  end

  logic [WIDTH-1:0] fin_sum;
  logic [WIDTH-1:0] fin_res;
  logic             fin_co;
  logic             fin_ov;

  always_comb begin
    fin_sum = s_nxt[LAST];
    fin_co  = seg_co[LAST];
    fin_ov  = seg_cm[LAST] ^ seg_co[LAST];
    fin_res = fin_sum;
    if (op_r[LAST] == OP_SLT) begin
      fin_res = {{(WIDTH-1){1'b0}}, fin_sum[WIDTH-1] ^ fin_ov};
    end
`ifdef ADDSUB_SLTU_EN
    else if (op_r[LAST] == OP_SLTU) begin
      fin_res = {{(WIDTH-1){1'b0}}, ~fin_co};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]  <= 1'b0;
        op_r[k] <= OP_ADD;
        a_r[k]  <= '0;
        b_r[k]  <= '0;
        s_r[k]  <= '0;
        c_r[k]  <= 1'b0;
      end
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      cout      <= 1'b0;
    end else if (adv) begin
      v_r[0]  <= in_valid;
      op_r[0] <= op_in;
      a_r[0]  <= a;
      b_r[0]  <= op_is_sub(op_in) ? ~b : b;
      s_r[0]  <= '0;
      c_r[0]  <= op_is_sub(op_in);
      for (int k = 1; k < STAGES; k++) begin
        v_r[k]  <= v_r[k-1];
        op_r[k] <= op_r[k-1];
        a_r[k]  <= a_r[k-1];
        b_r[k]  <= b_r[k-1];
        s_r[k]  <= s_nxt[k-1];
        c_r[k]  <= seg_co[k-1];
      end
      out_valid <= v_r[LAST];
      if (v_r[LAST]) begin
        result   <= fin_res;
        zero     <= (fin_res == '0);
        overflow <= fin_ov;
        cout     <= fin_co;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - directed self-checking bench for pipelined_add_sub (WIDTH 32, STAGES 4)
module tb_pipelined_add_sub;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        cout;

  int n_vec;
  int n_err;

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // One isolated beat into an empty pipeline with out_ready high; checks latency and all outputs.
  task automatic single(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eres, input logic ez, input logic ev, input logic ec);
    int lat;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_result"}, result, eres);
    checkb({tag, "_zero"}, zero, ez);
    checkb({tag, "_overflow"}, overflow, ev);
    checkb({tag, "_cout"}, cout, ec);
  endtask

  logic [1:0]  s_op  [8];
  logic [31:0] s_a   [8];
  logic [31:0] s_b   [8];
  logic [31:0] s_exp [8];

  initial begin
    int sent;
    int got;
    int lat;
    int stale;
    logic        held_ok;
    logic [31:0] held;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; a = '0; b = '0;

    s_op  = '{OP_ADD, OP_SUB, OP_SLT, OP_ADD, OP_SUB, OP_SLT, OP_ADD, OP_SLT};
    s_a   = '{32'h1, 32'hA, 32'h3, 32'hFFFF_FFFF, 32'h0, 32'h9, 32'h100, 32'hFFFF_FFFF};
    s_b   = '{32'h2, 32'h3, 32'h9, 32'hFFFF_FFFF, 32'h1, 32'h3, 32'h200, 32'h0};
    s_exp = '{32'h3, 32'h7, 32'h1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h300, 32'h1};

    #12;
    checkb("reset_out_valid", out_valid, 1'b0);
    check("reset_result", result, 32'h0);
    checkb("reset_zero", zero, 1'b0);
    checkb("reset_overflow", overflow, 1'b0);
    checkb("reset_cout", cout, 1'b0);
    checkb("reset_in_ready", in_ready, 1'b1);

    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    single("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1);
    single("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    single("slt_ovf", OP_SLT, 32'h8000_0000, 32'h1, 32'h1, 1'b0, 1'b1, 1'b1);
    single("slt_eq", OP_SLT, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b1);
    single("sub_neg", OP_SUB, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    single("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`ifdef ADDSUB_SLTU_EN
    single("op10_sltu", 2'b10, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
`else
    single("op10_add", 2'b10, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1);
`endif

    // Eight back-to-back beats, consumer stalls for three cycles once results flow.
    sent = 0; got = 0; held_ok = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 9);
      #1;
      if (out_valid && !out_ready) begin
        checkb("stall_in_ready", in_ready, 1'b0);
        if (held_ok) check("stall_hold", result, held);
        held = result;
        held_ok = 1'b1;
      end
      if (out_valid && out_ready) begin
        check($sformatf("stream_beat%0d", got), result, s_exp[got]);
        got++;
      end
      if (sent < 8) begin
        op = s_op[sent]; a = s_a[sent]; b = s_b[sent]; in_valid = 1'b1;
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    check("stream_count", 32'(got), 32'd8);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("stream_no_dup", 32'(stale), 32'd0);

    // Three beats in flight, head stalled at the output, then an asynchronous reset.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op = OP_ADD; a = 32'h10 + 32'(i); b = 32'h20; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkb("rst_pre_valid", out_valid, 1'b1);
    check("rst_pre_result", result, 32'h30);
    #2;
    rst_n = 1'b0;
    #1;
    checkb("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'h0);
    checkb("rst_zero", zero, 1'b0);
    checkb("rst_overflow", overflow, 1'b0);
    checkb("rst_cout", cout, 1'b0);
    checkb("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_no_stale", 32'(stale), 32'd0);
    single("post_rst_add", OP_ADD, 32'h3, 32'h4, 32'h7, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

Parametrised, pipelined add/subtract/set-less-than unit with a valid/ready handshake on both sides. The carry chain is split into STAGES equal segments, one per register stage, so WIDTH scales without a long combinational ripple. It returns result plus Zero/Overflow/Cout flags and serves as the arithmetic lane of the ALU datapath. Unlike the single-cycle add/sub block, its SLT result is overflow-corrected.

## Interface
- WIDTH, 32: operand/result width; ≥2.
- STAGES, 4: pipeline depth = carry segments; must divide WIDTH; 1..WIDTH.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit accepts a beat this cycle.
- op  in  2  00 ADD, 01 SUB, 11 SLT, 10 SLTU/reserved (see Configuration).
- a, b  in  WIDTH  operands.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum, difference, or zero-extended compare bit.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow of the underlying add/subtract.
- cout  out  1  carry out of the MSB of the underlying add/subtract.

## Operation
- Underlying operation: sum = a + (sub ? ~b : b) + sub; sub = 1 for SUB, SLT, SLTU.
- Stage k (0..STAGES-1) adds segment k (bits k·SEG..k·SEG+SEG-1, SEG = WIDTH/STAGES) with the carry registered from stage k-1; stage 0 uses sub as carry-in. Unprocessed operand segments and completed sum segments ride forward in skew registers.
- overflow = carry into MSB XOR carry out of MSB; cout = carry out of MSB; both are reported for every op.
- SLT: result = {0…, sum[MSB] XOR overflow}. SLTU: result = {0…, ~cout}.
- zero computed on the final result (after SLT selection).
- Each stage holds a valid bit; the op code travels with the beat.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. All stages shift when adv = 1; no stage moves when adv = 0. Bubbles are not compressed.
- Beat accepted on a rising edge with in_valid && in_ready; beat consumed on out_valid && out_ready.

## Timing
- Reset: all valid bits 0; result, zero, overflow, cout = 0; out_valid = 0; in_ready = 1 once rst_n is low.
- Latency: out_valid rises exactly STAGES cycles after the accept edge, given no stall. STAGES = 1 gives a single registered cycle.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, result and flags hold stable, in_ready = 0, and no beat is lost or duplicated.
- Simultaneous consume and accept in one cycle is legal at full rate.
- Reset mid-operation: in-flight beats are discarded and out_valid drops asynchronously. No stale beat appears after rst_n rises.
- Outputs are registered. in_ready is combinational from out_valid and out_ready only.

## Configuration
- ADDSUB_SLTU_EN defined: op 10 = SLTU (unsigned compare, result = ~cout).
- ADDSUB_SLTU_EN undefined: op 10 is decoded as ADD, and no SLTU logic is built.

## Structure
- Shared package alu_pkg: op encoding constants (OP_ADD, OP_SUB, OP_SLTU, OP_SLT) and the op_t typedef.
- Sub-module add_segment: SEG-bit ripple adder with carry-in, carry-out and carry-into-MSB outputs. It is instantiated once per stage via generate.
- Parameter checks (WIDTH % STAGES == 0) are elaboration-time assertions.

## Test plan
- ADD a=0xFFFFFFFF, b=1 (WIDTH 32, STAGES 4) -> result 0, zero=1, cout=1, overflow=0, out_valid 4 cycles after accept.
- SUB a=0x80000000, b=1 -> result 0x7FFFFFFF, overflow=1, cout=1, zero=0.
- SLT a=0x80000000, b=1 -> result 1 (overflow-corrected); SLT a=5, b=5 -> result 0, zero=1.
- 8 back-to-back ops with out_ready low for 3 cycles mid-stream -> all 8 results in order, no loss or duplication, result held during stall, in_ready=0 during stall.
- rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, all outputs 0, no result emerges after release; next accepted beat completes in 4 cycles.
- op=10, a=1, b=0xFFFFFFFF: with ADDSUB_SLTU_EN -> result 1; without -> result 0, cout=1 (ADD).
